l1_automask_ctrl: RTL
=====================

Name: l1_automask_ctrl

Overview:
- Rate-servo controller for the dual-phi L1/L2 trigger datapath.
- Counts per-channel single-pol trigger pulses over a programmable window, then evaluates each channel against a rate limit.
- Drives the 12-bit channel mask back into the trigger block, so hot antennas are removed automatically.
- Sits between the trigger block's mask input and the register interface; user mask is ORed in.

Parameters:
NCHAN, 12, number of channels (6 per phi sector x 2).
CNT_WIDTH, 16, per-channel scaler counter width (saturating).
PERIOD_WIDTH, 24, width of the window-length register.
HOLDOFF_WINDOWS, 4, windows a channel stays auto-masked before release (release feature only).

Ports:
clk_i  input  1  single clock; all logic on rising edge.
rst_i  input  1  synchronous active-high reset.
enable_i  input  1  run servo; low forces IDLE.
clear_i  input  1  one-cycle pulse; clears all auto-mask bits.
period_i  input  PERIOD_WIDTH  window length in clk_i cycles.
limit_i  input  CNT_WIDTH  max allowed count per window.
user_mask_i  input  NCHAN  software mask, always applied.
scaler_i  input  NCHAN  per-channel single-cycle trigger pulses, already in clk_i domain.
rd_addr_i  input  4  channel select for latched-count readback.
mask_o  output  NCHAN  registered mask to trigger block = user_mask_i | auto_mask.
auto_mask_o  output  NCHAN  auto-mask bits alone.
rd_data_o  output  CNT_WIDTH  latched count of channel rd_addr_i.
update_o  output  1  one-cycle strobe after each evaluation completes.
busy_o  output  1  high in any state except IDLE.

Behaviour:
- Reset: all counters, shadow counts and auto_mask = 0; mask_o = 0; rd_data_o = 0; update_o = 0; state = IDLE.
- mask_o is re-registered every cycle from user_mask_i | auto_mask, independent of state. 1-cycle latency.
- States: IDLE, COUNT, LATCH, EVAL, DONE.
- IDLE -> COUNT when enable_i = 1. Window counter loads the effective period Peff = max(period_i, NCHAN+2).
- Counting: each scaler_i[k] pulse increments cnt[k] in every non-IDLE state. cnt[k] saturates at 2^CNT_WIDTH-1 with no wrap.
- The window counter decrements every non-IDLE cycle. LATCH occurs every Peff cycles exactly.
- COUNT -> LATCH when the window counter reaches 1.
- LATCH (1 cycle):
  - shadow[k] <= cnt[k].
  - cnt[k] <= scaler_i[k]; a pulse in this cycle counts toward the new window.
  - Window counter reloads Peff.
  - Channel index idx <= 0.
- EVAL (NCHAN cycles): one channel per cycle through a single comparator. If shadow[idx] > limit_i (strict), set auto_mask[idx]. idx increments; after idx = NCHAN-1 go to DONE.
- DONE (1 cycle): update_o = 1, then -> COUNT.
- limit_i and period_i are sampled live; a change takes effect at the next comparison or reload.
- enable_i low in any state:
  - Next state is IDLE.
  - cnt and window counter cleared.
  - shadow and auto_mask retained.
  - An in-progress EVAL is abandoned with no update_o.
- clear_i: auto_mask <= 0 next cycle. If it coincides with an EVAL set, clear wins for that cycle.
- A channel with user_mask_i[k] = 1 still counts and is still evaluated.
- Readback: rd_data_o <= shadow[rd_addr_i], 1-cycle latency. rd_addr_i >= NCHAN returns 0.
- rst_i mid-window: everything returns to reset values next cycle. No partial update_o.

Optional Feature:
- Macro AUTOMASK_RELEASE_EN, defined: each channel has a holdoff counter (clog2(HOLDOFF_WINDOWS+1) bits).
  - Loaded with HOLDOFF_WINDOWS when its auto_mask bit sets.
  - At each EVAL of a masked channel with shadow <= limit_i, it decrements. When it reaches 0, the auto_mask bit clears.
  - A channel over limit while masked reloads the holdoff.
  - clear_i zeroes the holdoffs.
- Macro undefined: auto-mask bits are sticky until clear_i or rst_i; no holdoff logic is built.

Decomposition:
- Shared package `l1_automask_pkg`: NCHAN, state enum encoding, function clog2, readback-address width.
- Natural sub-module `sat_scaler_counter`: one saturating CNT_WIDTH counter with load-with-value (the LATCH restart) and increment. Instantiated NCHAN times.

Test Plan:
- period_i=100, limit_i=5; 6 pulses on ch3 and 5 on ch7 within a window -> after LATCH+12+1 cycles update_o pulses; auto_mask_o = 0x008, mask_o = 0x008 one cycle later.
- period_i=4 (below NCHAN+2) -> LATCH spacing measured as exactly 14 cycles.
- Continuous pulses on ch0 for 70000 cycles, period_i=80000 -> rd_data_o(addr 0) = 65535 (saturated, no wrap).
- Pulse on ch2 in the LATCH cycle -> that window's shadow excludes it; next window's shadow[2] includes it (count 1).
- clear_i asserted in the EVAL cycle that would set ch5 -> auto_mask[5] = 0 afterward; enable_i dropped mid-EVAL -> busy_o = 0 next cycle, no update_o.
- AUTOMASK_RELEASE_EN, HOLDOFF_WINDOWS=4: ch9 over limit once, then quiet -> mask bit set for exactly 4 further updates, clears at the 4th; undefined build -> bit stays set.

Source files
------------

// File: rtl/l1_automask_pkg.sv
// l1_automask_pkg: shared definitions for the L1/L2 trigger auto-mask servo.
//   NCHAN      - number of trigger channels (6 per phi sector x 2)
//   RD_AW      - width of the latched-count readback address
//   state_t    - servo FSM state encoding
//   clog2()    - ceiling log2 used to size the per-channel holdoff counters
package l1_automask_pkg;

  localparam int NCHAN = 12;
  localparam int RD_AW = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_COUNT = 3'd1,
    ST_LATCH = 3'd2,
    ST_EVAL  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sat_scaler_counter.sv
// sat_scaler_counter: one saturating per-channel trigger scaler.
//   clk_i      - clock
//   rst_i      - synchronous active-high reset
//   clr_i      - synchronous clear (servo disabled)
//   load_i     - restart the count with load_val_i (window boundary)
//   load_val_i - value to restart with (the pulse arriving in the boundary cycle)
//   inc_i      - count one pulse
//   cnt_o      - current count, sticks at all-ones instead of wrapping
module sat_scaler_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_reg <= '0;
    end else if (load_i) begin
      cnt_reg <= load_val_i;
    end else if (inc_i && (cnt_reg != '1)) begin
      cnt_reg <= cnt_reg + W'(1);
    end
  end

  assign cnt_o = cnt_reg;

endmodule

// File: rtl/l1_automask_ctrl.sv
// l1_automask_ctrl: rate servo that auto-masks hot trigger channels.
// Counts single-pol trigger pulses per channel over a window of Peff =
// max(period_i, NCHAN+2) cycles, latches the counts, then walks the channels
// through one comparator and masks any channel whose count exceeds limit_i.
//   clk_i/rst_i  - clock, synchronous active-high reset
//   enable_i     - run servo; low returns to IDLE and clears the live counts
//   clear_i      - pulse: clear all auto-mask bits
//   period_i     - window length in cycles (sampled at each reload)
//   limit_i      - max allowed count per window (strict greater-than masks)
//   user_mask_i  - software mask, ORed into mask_o
//   scaler_i     - per-channel trigger pulses
//   rd_addr_i    - channel select for latched-count readback
//   mask_o       - registered user_mask_i | auto mask
//   auto_mask_o  - auto-mask bits alone
//   rd_data_o    - latched count of channel rd_addr_i (0 when out of range)
//   update_o     - one-cycle strobe when an evaluation pass completes
//   busy_o       - servo not idle
// Build option: define AUTOMASK_RELEASE_EN to release auto-masked channels
// after HOLDOFF_WINDOWS consecutive quiet evaluations; otherwise auto-mask
// bits are sticky until clear_i or rst_i.
module l1_automask_ctrl
  import l1_automask_pkg::*;
#(
  parameter int CNT_WIDTH    = 16,
  parameter int PERIOD_WIDTH = 24
`ifdef AUTOMASK_RELEASE_EN
  ,
  parameter int HOLDOFF_WINDOWS = 4
`endif
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    enable_i,
  input  logic                    clear_i,
  input  logic [PERIOD_WIDTH-1:0] period_i,
  input  logic [CNT_WIDTH-1:0]    limit_i,
  input  logic [NCHAN-1:0]        user_mask_i,
  input  logic [NCHAN-1:0]        scaler_i,
  input  logic [RD_AW-1:0]        rd_addr_i,
  output logic [NCHAN-1:0]        mask_o,
  output logic [NCHAN-1:0]        auto_mask_o,
  output logic [CNT_WIDTH-1:0]    rd_data_o,
  output logic                    update_o,
  output logic                    busy_o
);

  // Shortest window that still fits LATCH + NCHAN EVAL cycles + DONE.
  localparam logic [PERIOD_WIDTH-1:0] PERIOD_MIN = PERIOD_WIDTH'(NCHAN + 2);

  state_t                  state_reg, state_next;
  logic [PERIOD_WIDTH-1:0] wcnt_reg;
  logic [PERIOD_WIDTH-1:0] peff;
  logic [RD_AW-1:0]        idx_reg;
  logic [CNT_WIDTH-1:0]    cnt [NCHAN];
  logic [CNT_WIDTH-1:0]    shadow_reg [NCHAN];
  logic [NCHAN-1:0]        auto_mask_reg;
  logic                    window_end;
  logic                    eval_en;
  logic                    over_limit;

  assign peff = (period_i < PERIOD_MIN) ? PERIOD_MIN : period_i;

  // The window counter holds 1 during the LATCH cycle, so the FSM leaves for
  // LATCH while it holds 2. With the minimum window there is no COUNT cycle at
  // all, hence DONE may also go straight to LATCH.
  assign window_end = (wcnt_reg == PERIOD_WIDTH'(2));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (enable_i) state_next = ST_COUNT;
      ST_COUNT: if (window_end) state_next = ST_LATCH;
      ST_LATCH: state_next = ST_EVAL;
      ST_EVAL:  if (idx_reg == RD_AW'(NCHAN - 1)) state_next = ST_DONE;
      ST_DONE:  state_next = window_end ? ST_LATCH : ST_COUNT;
      default:  state_next = ST_IDLE;
    endcase
    if (!enable_i) begin
      state_next = ST_IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= ST_IDLE;
      wcnt_reg  <= '0;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (!enable_i) begin
        wcnt_reg <= '0;
      end else if ((state_reg == ST_IDLE) || (state_reg == ST_LATCH)) begin
        wcnt_reg <= peff;
      end else if (wcnt_reg != '0) begin
        wcnt_reg <= wcnt_reg - PERIOD_WIDTH'(1);
      end
      if (state_reg == ST_LATCH) begin
        idx_reg <= '0;
      end else if (state_reg == ST_EVAL) begin
        idx_reg <= idx_reg + RD_AW'(1);
      end
    end
  end

  // Per-channel scalers; a pulse in the LATCH cycle seeds the next window.
  for (genvar gi = 0; gi < NCHAN; gi++) begin : g_scaler
    sat_scaler_counter #(
      .W (CNT_WIDTH)
    ) u_cnt (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .clr_i      (!enable_i),
      .load_i     (state_reg == ST_LATCH),
      .load_val_i ({{(CNT_WIDTH-1){1'b0}}, scaler_i[gi]}),
      .inc_i      (scaler_i[gi] && (state_reg != ST_IDLE)),
      .cnt_o      (cnt[gi])
    );
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < NCHAN; k++) begin
        shadow_reg[k] <= '0;
      end
    end else if ((state_reg == ST_LATCH) && enable_i) begin
      for (int k = 0; k < NCHAN; k++) begin
        shadow_reg[k] <= cnt[k];
      end
    end
  end

  // An EVAL cycle with enable_i low is being abandoned and must not touch the mask.
  assign eval_en    = (state_reg == ST_EVAL) && enable_i;
  assign over_limit = shadow_reg[idx_reg] > limit_i;

`ifdef AUTOMASK_RELEASE_EN
  localparam int HO_W = clog2(HOLDOFF_WINDOWS + 1);
  localparam logic [HO_W-1:0] HO_LOAD = HO_W'(HOLDOFF_WINDOWS);
  logic [HO_W-1:0] holdoff_reg [NCHAN];
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      auto_mask_reg <= '0;
`ifdef AUTOMASK_RELEASE_EN
      for (int k = 0; k < NCHAN; k++) begin
        holdoff_reg[k] <= '0;
      end
`endif
    end else if (eval_en) begin
      if (over_limit) begin
        auto_mask_reg[idx_reg] <= 1'b1;
`ifdef AUTOMASK_RELEASE_EN
        holdoff_reg[idx_reg] <= HO_LOAD;
      end else if (auto_mask_reg[idx_reg]) begin
        // Quiet window while masked: count down, release on the last one.
        if (holdoff_reg[idx_reg] <= HO_W'(1)) begin
          auto_mask_reg[idx_reg] <= 1'b0;
          holdoff_reg[idx_reg]   <= '0;
        end else begin
          holdoff_reg[idx_reg] <= holdoff_reg[idx_reg] - HO_W'(1);
        end
`endif
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mask_o    <= '0;
      rd_data_o <= '0;
    end else begin
      mask_o    <= user_mask_i | auto_mask_reg;
      rd_data_o <= (rd_addr_i < RD_AW'(NCHAN)) ? shadow_reg[rd_addr_i] : '0;
    end
  end

  assign auto_mask_o = auto_mask_reg;
  assign update_o    = (state_reg == ST_DONE);
  assign busy_o      = (state_reg != ST_IDLE);

endmodule
